matbi_watch_time_counter: RTL and testbench
===========================================

Name: matbi_watch_time_counter

Overview:
- Consumer end of the one-second tick interface. Takes the single-cycle one-second tick and keeps time of day as seconds, minutes and hours.
- Emits carry pulses at minute, hour and day roll-over.
- Accepts a validated time-set request over a valid/ready handshake.
- Sits between the tick generator and the display/alarm logic of the watch.

Parameters:
- P_HOUR_MOD, 24: hour modulus; legal values 12 or 24; hours count 0..P_HOUR_MOD-1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to clk.
- i_run_en  in  1  1 = ticks advance time; 0 = time frozen.
- i_one_sec_tick  in  1  one-cycle pulse, one per second.
- i_set_valid  in  1  time-set request valid.
- o_set_ready  out  1  block can accept a time-set request.
- i_set_hour  in  5  requested hour.
- i_set_min  in  6  requested minute.
- i_set_sec  in  6  requested second.
- o_set_err  out  1  one-cycle pulse: request rejected as out of range.
- o_hour  out  5  current hour.
- o_min  out  6  current minute.
- o_sec  out  6  current second.
- o_min_carry  out  1  one-cycle pulse when seconds wrap 59->0.
- o_hour_carry  out  1  one-cycle pulse when minutes wrap 59->0.
- o_day_carry  out  1  one-cycle pulse when hours wrap P_HOUR_MOD-1->0.

Behaviour:
- Reset values: every output is 0, except o_set_ready = 1. The state machine resets to S_STOP.
- States:
  - S_STOP: time frozen. Goes to S_RUN when i_run_en = 1.
  - S_RUN: counting. Goes to S_STOP when i_run_en = 0.
  - S_LOAD: one cycle after a set acceptance, then returns to S_RUN or S_STOP according to i_run_en.
- Counting happens in S_RUN, or in S_LOAD with i_run_en = 1, when i_one_sec_tick = 1. The counters update at the same clk edge where the tick is sampled.
- Counting carries:
  - o_sec increments; at 59 it goes to 0 and o_min increments.
  - o_min at 59 with a carry in goes to 0 and o_hour increments.
  - o_hour at P_HOUR_MOD-1 with a carry in goes to 0.
- Carry pulses are registered and high for exactly the cycle after the wrap edge, aligned with the new counter values. All three pulse together at 23:59:59 -> 00:00:00 (P_HOUR_MOD = 24).
- A tick arriving while in S_STOP is discarded, not queued. A tick arriving when i_run_en is 0 in any state is also discarded.
- Set handshake: a request is accepted on a clk edge where i_set_valid & o_set_ready = 1.
- o_set_ready = 0 only in S_LOAD, so back-to-back requests are accepted one every 2 cycles.
- Range check on acceptance:
  - Legal: i_set_hour < P_HOUR_MOD, i_set_min < 60, i_set_sec < 60.
  - Legal request: counters load the request at the acceptance edge and the FSM enters S_LOAD. No carry pulses fire.
  - Illegal request: counters are unchanged, o_set_err pulses for 1 cycle, the FSM stays in its current state, and o_set_ready stays 1.
- A tick in the acceptance cycle is dropped; the loaded value wins. A tick in the S_LOAD cycle advances the loaded value normally when i_run_en = 1.
- Requester rule: the request must hold stable while i_set_valid = 1 and o_set_ready = 0. The block does not re-check inputs it has not yet accepted.
- An accepted set is allowed in S_STOP and in S_RUN.
- Reset asserted mid-count or mid-load: everything returns to reset values asynchronously, and a pending request is not accepted.
- Widths: counters are fixed-width unsigned. Comparisons are width-extended so no truncation occurs; 5-bit hour covers P_HOUR_MOD up to 24.

Test Plan:
- Reset then run: reset low 3 cycles, release, i_run_en = 1, 60 ticks 10 cycles apart -> o_sec 0..59 then 0, o_min = 1, one o_min_carry pulse after the 60th tick.
- Day wrap: set 23:59:58 in S_STOP, i_run_en = 1, 2 ticks -> 23:59:59, then 00:00:00 with o_min_carry, o_hour_carry and o_day_carry all high the same single cycle. With P_HOUR_MOD = 12, set 11:59:59 + 1 tick -> 00:00:00 plus day carry.
- Freeze: at 00:00:10, i_run_en = 0, 5 ticks -> time stays 00:00:10, no carries. Re-enable, 1 tick -> 00:00:11.
- Illegal set: request 24:00:00, or 10:60:00 -> o_set_err pulses 1 cycle, time unchanged, o_set_ready stays 1. Then request 10:20:30 -> loaded, o_set_ready low exactly 1 cycle.
- Set/tick collision: running at 05:00:00, accepted set 12:34:56 with a tick in the same cycle -> 12:34:56. A tick in the next (S_LOAD) cycle -> 12:34:57.
- Async reset mid-operation: assert reset between clk edges while running at 01:02:03 with i_set_valid = 1 -> outputs clear before the next edge, o_set_ready = 1, request not applied.

Source files
------------

// File: rtl/matbi_watch_time_counter.sv
// Time-of-day counter driven by a one-second tick, with a validated time-set handshake.
// Counters update on the tick edge; carry pulses and set errors are registered one cycle later.
module matbi_watch_time_counter #(
  parameter int P_HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_en,
  input  logic       i_one_sec_tick,
  input  logic       i_set_valid,
  output logic       o_set_ready,
  input  logic [4:0] i_set_hour,
  input  logic [5:0] i_set_min,
  input  logic [5:0] i_set_sec,
  output logic       o_set_err,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_min_carry,
  output logic       o_hour_carry,
  output logic       o_day_carry
);

  localparam logic [5:0] LP_HOUR_MOD = 6'(P_HOUR_MOD);
  localparam logic [4:0] LP_HOUR_MAX = 5'(P_HOUR_MOD - 1);

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_min_carry;
  logic       r_hour_carry;
  logic       r_day_carry;
  logic       r_set_err;

  logic w_accept;
  logic w_legal;
  logic w_load;
  logic w_count;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;

  assign o_set_ready = (r_state != S_LOAD);
  assign w_accept    = i_set_valid & o_set_ready;
  assign w_legal     = ({1'b0, i_set_hour} < LP_HOUR_MOD) &&
                       (i_set_min < 6'd60) && (i_set_sec < 6'd60);
  assign w_load      = w_accept & w_legal;

  // Any accepted request, legal or not, swallows a coincident tick.
  assign w_count     = i_one_sec_tick & i_run_en & (r_state != S_STOP) & ~w_accept;
  assign w_sec_wrap  = w_count & (r_sec == 6'd59);
  assign w_min_wrap  = w_sec_wrap & (r_min == 6'd59);
  assign w_hour_wrap = w_min_wrap & (r_hour == LP_HOUR_MAX);

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = S_LOAD;
    end else if (!w_accept) begin
      w_state_nxt = i_run_en ? S_RUN : S_STOP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hour <= 5'd0;
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
    end else if (w_load) begin
      r_hour <= i_set_hour;
      r_min  <= i_set_min;
      r_sec  <= i_set_sec;
    end else if (w_count) begin
      r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
      if (w_sec_wrap) begin
        r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
      end
      if (w_min_wrap) begin
        r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min_carry  <= 1'b0;
      r_hour_carry <= 1'b0;
      r_day_carry  <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_min_carry  <= w_sec_wrap;
      r_hour_carry <= w_min_wrap;
      r_day_carry  <= w_hour_wrap;
      r_set_err    <= w_accept & ~w_legal;
    end
  end

  assign o_hour       = r_hour;
  assign o_min        = r_min;
  assign o_sec        = r_sec;
  assign o_min_carry  = r_min_carry;
  assign o_hour_carry = r_hour_carry;
  assign o_day_carry  = r_day_carry;
  assign o_set_err    = r_set_err;

endmodule

// File: tb/tb_matbi_watch_time_counter.sv
// Bench for the watch time counter: 24-hour and 12-hour instances share stimulus and are
// checked every cycle against a seconds-of-day reference model.
module tb_matbi_watch_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       i_run_en;
  logic       i_one_sec_tick;
  logic       i_set_valid;
  logic [4:0] i_set_hour;
  logic [5:0] i_set_min;
  logic [5:0] i_set_sec;

  logic       o_set_ready  [2];
  logic       o_set_err    [2];
  logic [4:0] o_hour       [2];
  logic [5:0] o_min        [2];
  logic [5:0] o_sec        [2];
  logic       o_min_carry  [2];
  logic       o_hour_carry [2];
  logic       o_day_carry  [2];

  matbi_watch_time_counter #(.P_HOUR_MOD(24)) u_dut24 (
    .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_one_sec_tick(i_one_sec_tick),
    .i_set_valid(i_set_valid), .o_set_ready(o_set_ready[0]),
    .i_set_hour(i_set_hour), .i_set_min(i_set_min), .i_set_sec(i_set_sec),
    .o_set_err(o_set_err[0]), .o_hour(o_hour[0]), .o_min(o_min[0]), .o_sec(o_sec[0]),
    .o_min_carry(o_min_carry[0]), .o_hour_carry(o_hour_carry[0]), .o_day_carry(o_day_carry[0])
  );

  matbi_watch_time_counter #(.P_HOUR_MOD(12)) u_dut12 (
    .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_one_sec_tick(i_one_sec_tick),
    .i_set_valid(i_set_valid), .o_set_ready(o_set_ready[1]),
    .i_set_hour(i_set_hour), .i_set_min(i_set_min), .i_set_sec(i_set_sec),
    .o_set_err(o_set_err[1]), .o_hour(o_hour[1]), .o_min(o_min[1]), .o_sec(o_sec[1]),
    .o_min_carry(o_min_carry[1]), .o_hour_carry(o_hour_carry[1]), .o_day_carry(o_day_carry[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time as seconds since midnight; phase 0=frozen, 1=running, 2=loading.
  int mods [2] = '{24, 12};
  int m_t  [2];
  int m_ph [2];
  bit m_mc [2], m_hc [2], m_dc [2], m_err [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_ph[k] = 0;
      m_mc[k] = 0; m_hc[k] = 0; m_dc[k] = 0; m_err[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      bit acc, legal, cnt;
      acc   = i_set_valid && (m_ph[k] != 2);
      legal = (int'(i_set_hour) < mods[k]) && (i_set_min < 60) && (i_set_sec < 60);
      cnt   = i_one_sec_tick && i_run_en && (m_ph[k] != 0) && !acc;
      m_mc[k] = 0; m_hc[k] = 0; m_dc[k] = 0;
      m_err[k] = acc && !legal;
      if (acc && legal) begin
        m_t[k]  = int'(i_set_hour) * 3600 + int'(i_set_min) * 60 + int'(i_set_sec);
        m_ph[k] = 2;
      end else if (!acc) begin
        if (cnt) begin
          m_t[k]  = (m_t[k] + 1) % (mods[k] * 3600);
          m_mc[k] = (m_t[k] % 60) == 0;
          m_hc[k] = (m_t[k] % 3600) == 0;
          m_dc[k] = m_t[k] == 0;
        end
        m_ph[k] = i_run_en ? 1 : 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "m24" : "m12";
      chk({p, ".hour"},  int'(o_hour[k]),       m_t[k] / 3600);
      chk({p, ".min"},   int'(o_min[k]),        (m_t[k] / 60) % 60);
      chk({p, ".sec"},   int'(o_sec[k]),        m_t[k] % 60);
      chk({p, ".mcar"},  int'(o_min_carry[k]),  int'(m_mc[k]));
      chk({p, ".hcar"},  int'(o_hour_carry[k]), int'(m_hc[k]));
      chk({p, ".dcar"},  int'(o_day_carry[k]),  int'(m_dc[k]));
      chk({p, ".err"},   int'(o_set_err[k]),    int'(m_err[k]));
      chk({p, ".ready"}, int'(o_set_ready[k]),  int'(m_ph[k] != 2));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick();
    i_one_sec_tick = 1'b1;
    cycle();
    i_one_sec_tick = 1'b0;
    idle(2);
  endtask

  task automatic do_set(input int h, input int m, input int s);
    i_set_hour  = 5'(h);
    i_set_min   = 6'(m);
    i_set_sec   = 6'(s);
    i_set_valid = 1'b1;
    cycle();
    i_set_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; i_run_en = 1'b0; i_one_sec_tick = 1'b0; i_set_valid = 1'b0;
    i_set_hour = '0; i_set_min = '0; i_set_sec = '0;
    model_reset();
    #1;
    check_all();
    idle(3);
    @(negedge clk);
    reset = 1'b1;

    // Count a full minute
    i_run_en = 1'b1;
    idle(1);
    for (int i = 0; i < 60; i++) begin
      i_one_sec_tick = 1'b1;
      cycle();
      i_one_sec_tick = 1'b0;
      idle(9);
    end
    chk("minute_done", int'(o_min[0]), 1);

    // Day wrap in both moduli
    i_run_en = 1'b0;
    idle(1);
    do_set(23, 59, 58);
    i_run_en = 1'b1;
    tick();
    tick();
    do_set(11, 59, 59);
    tick();

    // Freeze and resume
    do_set(0, 0, 10);
    i_run_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    i_run_en = 1'b1;
    idle(1);
    tick();

    // Illegal requests followed by a legal one
    do_set(24, 0, 0);
    idle(1);
    do_set(10, 60, 0);
    idle(1);
    do_set(10, 20, 30);
    idle(2);

    // Set colliding with a tick, then a tick in the load cycle
    do_set(5, 0, 0);
    idle(2);
    i_one_sec_tick = 1'b1;
    do_set(12, 34, 56);
    cycle();
    i_one_sec_tick = 1'b0;
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) i_run_en = ~i_run_en;
      i_one_sec_tick = ($urandom_range(0, 3) == 0);
      if (!i_set_valid || (m_ph[0] != 2 && m_ph[1] != 2)) begin
        i_set_valid = ($urandom_range(0, 9) == 0);
        i_set_hour  = 5'($urandom_range(0, 31));
        i_set_min   = 6'($urandom_range(0, 63));
        i_set_sec   = 6'($urandom_range(0, 63));
      end
      cycle();
    end
    i_set_valid = 1'b0; i_one_sec_tick = 1'b0;

    // Asynchronous reset between edges with a pending request
    i_run_en = 1'b1;
    idle(1);
    do_set(1, 2, 3);
    idle(2);
    i_set_hour = 5'd7; i_set_min = 6'd8; i_set_sec = 6'd9;
    i_set_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    @(negedge clk);
    reset = 1'b1;
    i_set_valid = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
